// File: rtl/async_ring_ctrl_pkg.sv
// async_ctrl_pkg: controller state encoding and ring reset length
package async_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, RING_RST, RUN, HOLD, ACK, FINISH} state_t;
    localparam int RING_RST_CYCLES = 4;
endpackage

// File: rtl/async_ring_ctrl_if.sv
// async_ring_ctrl_if: valid/ready channel carrying captured ring words
interface async_ring_ctrl_if #(parameter int N = 8);
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_data;
    modport master(output m_valid, m_data, input m_ready);
    modport slave(input m_valid, m_data, output m_ready);
endinterface

// File: rtl/async_ring_ctrl_req_sync.sv
// req_sync: flop chain synchroniser with synchronous clear for the ring request
module req_sync #(parameter int STAGES = 2) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk) sr <= clr ? '0 : {sr[STAGES-2:0], d};
    assign q = sr[STAGES-1];
endmodule

// File: rtl/async_ring_ctrl.sv
// async_ring_ctrl: runs the self-timed ring and hands its words to a valid/ready consumer
module async_ring_ctrl
    import async_ctrl_pkg::*;
#(
    parameter int N           = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             ring_r_i,
    input  logic [N-1:0]     ring_d_i,
    output logic             ring_a_o,
    output logic             ring_rst_o,
    async_ring_ctrl_if.master m,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] tok_count
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(RING_RST_CYCLES);
    state_t           state;
    logic             sreq, stop_pend;
    logic [CNT_W-1:0] blen;
    logic [RC_W-1:0]  rc;
    logic [WD_W-1:0]  wd;
    req_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .clr(rst || state == RING_RST),
        .d  (ring_r_i),
        .q  (sreq)
    );
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ring_a_o    <= 1'b0;
            ring_rst_o  <= 1'b1;
            m.m_valid   <= 1'b0;
            m.m_data    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            tok_count   <= '0;
            blen        <= '0;
            rc          <= '0;
            wd          <= '0;
            stop_pend   <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == RUN || state == HOLD) && stop) stop_pend <= 1'b1;
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (start) begin
                        blen        <= burst_len;
                        tok_count   <= '0;
                        timeout_err <= 1'b0;
                        rc          <= '0;
                        ring_a_o    <= 1'b0;
                        state       <= RING_RST;
                    end
                end
                RING_RST: begin
                    if (rc == RC_W'(RING_RST_CYCLES - 1)) begin
                        ring_rst_o <= 1'b0;
                        wd         <= '0;
                        state      <= RUN;
                    end else rc <= rc + 1'b1;
                end
                // ring data is stable from request edge until ack, so it is captured without synchronising
                RUN: begin
                    if (sreq != ring_a_o) begin
                        m.m_data  <= ring_d_i;
                        m.m_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        ring_rst_o  <= 1'b1;
                        state       <= FINISH;
                    end else wd <= wd + 1'b1;
                end
                HOLD: begin
                    if (m.m_ready) begin
                        m.m_valid <= 1'b0;
                        ring_a_o  <= ~ring_a_o;
                        tok_count <= tok_count + 1'b1;
                        state     <= ACK;
                    end
                end
                // one idle cycle lets the synchroniser catch up with the new ack
                ACK: begin
                    if (stop_pend || (blen != '0 && tok_count == blen)) begin
                        done       <= 1'b1;
                        ring_rst_o <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        wd    <= '0;
                        state <= RUN;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/async_ring_ctrl.md
# async_ring_ctrl

Clocked run controller for the self-timed incrementing ring (the hlatch/mullerc/delay token ring with an `N`-bit output channel). Resets the ring, releases it, synchronises its 2-phase output request, captures each bundled data word, and presents it to a synchronous valid/ready consumer. Acknowledges only after delivery, so the ring stalls under backpressure. Also enforces burst length, stop requests, and a no-token watchdog.

## Interface
- `N`, 8, ring data width
- `CNT_W`, 16, width of burst length and token counter
- `SYNC_STAGES`, 2, flops in request synchroniser (≥2)
- `TIMEOUT`, 255, max clk cycles in RUN without a new token
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a burst; sampled in IDLE only
- `stop`  in  1  end burst after current token; sampled in RUN/HOLD
- `burst_len`  in  CNT_W  tokens per burst, latched on `start`; 0 = unlimited
- `ring_r_i`  in  1  ring output request (`R_o`), 2-phase, asynchronous
- `ring_d_i`  in  N  ring output data (`D_o`), bundled with `ring_r_i`
- `ring_a_o`  out  1  ack to ring (`A_i`), 2-phase
- `ring_rst_o`  out  1  drives ring `rst`
- `m_valid`  out  1  captured word valid
- `m_ready`  in  1  consumer ready
- `m_data`  out  N  captured word
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on burst completion
- `timeout_err`  out  1  sticky watchdog flag, cleared on accepted `start`
- `tok_count`  out  CNT_W  tokens delivered in current/last burst

## Operation
- States: IDLE, RING_RST, RUN, HOLD, ACK, FINISH.
- IDLE: `ring_rst_o`=1. On `start`: latch `burst_len`, clear `tok_count` and `timeout_err`, go RING_RST.
- RING_RST: `ring_rst_o`=1 for `RING_RST_CYCLES` (4), `ring_a_o` forced 0, sync chain cleared. Then drop `ring_rst_o`, go RUN.
- RUN: token pending when synced request ≠ `ring_a_o`. On pending, capture `ring_d_i` into `m_data`, assert `m_valid`, go HOLD. Capture is unsynchronised. This is safe because data is stable from the request edge until ack, which is ≥`SYNC_STAGES` cycles.
- RUN watchdog: count cycles without a pending token. At `TIMEOUT` set `timeout_err` and go FINISH.
- HOLD: hold `m_valid`/`m_data` until `m_ready`. On handshake, drop `m_valid`, toggle `ring_a_o`, increment `tok_count`, go ACK.
- ACK: one cycle, so the synced request cannot show a stale token. Go FINISH if a stop is pending or `tok_count`==`burst_len` (nonzero). Otherwise go RUN with the watchdog cleared.
- Stop pending: set by `stop` in RUN/HOLD, cleared in IDLE.
- FINISH: pulse `done`, assert `ring_rst_o`, go IDLE. `m_valid` is never dropped without a handshake.
- `tok_count` wraps modulo 2^CNT_W when unlimited. It holds its value in IDLE.
- `start` outside IDLE is ignored.
- `stop` and `m_ready` in the same HOLD cycle: the word is delivered and acked, then FINISH.
- `rst` mid-burst: all state returns to reset values next cycle. The ring is held reset and in-flight data is discarded.

## Timing
- Reset values: `ring_rst_o`=1, `ring_a_o`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `timeout_err`=0, `tok_count`=0.
- Request edge to `m_valid`: `SYNC_STAGES`+1 cycles.
- `m_ready` handshake to `ring_a_o` toggle: registered, next cycle.
- Minimum token period as seen by the controller: `SYNC_STAGES`+3 cycles plus ring latency.
- `start` to ring release: 5 cycles (1 decode + 4 RING_RST).
- `done` is asserted the cycle after the final ack or timeout.

## Structure
- Package `async_ctrl_pkg`: state enum, `RING_RST_CYCLES`=4.
- Sub-module `req_sync`: `SYNC_STAGES`-deep flop chain with synchronous clear, for `ring_r_i`.
- The controller contains the FSM, data register, and counters.

## Test plan
- `start`, `burst_len`=3, ring model emits 0x01,0x02,0x03, `m_ready`=1 → three words in order, `ring_a_o` toggles 3×, `tok_count`=3, one `done`, then `ring_rst_o`=1.
- `m_ready` low 20 cycles on word 0x01 → `m_valid`/`m_data` stable, no ack toggle, ring stalls, no timeout raised.
- `burst_len`=0, `stop` asserted after 5th delivery, concurrent with 6th word's `m_ready` → 6 words, then `done`.
- Ring model silent, `TIMEOUT`=255 → `timeout_err`=1 at 255 cycles into RUN, `done` pulse, IDLE. Next `start` clears `timeout_err`.
- `rst` asserted in HOLD → next cycle all outputs at reset values. A following `start` runs cleanly from `tok_count`=0.
- `start` during RUN ignored, and `ring_d_i` toggled while no token pending → `m_data` unaffected.
